// File: rtl/prbs_checker.sv
// Receive-side checker for the Galois LFSR pattern generator: self-synchronises a
// local reference to the incoming word stream, tracks lock and counts errors.
module prbs_checker #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b0011,
  parameter int               LOCK_CNT   = 3,
  parameter int               UNLOCK_CNT = 4,
  parameter int               ERR_W      = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] expected
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_LIM   = MW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLOCK_LIM = UW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    lfsr_next = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : {WIDTH{1'b0}});
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] expected_r, expected_s;
  logic [MW-1:0]    match_cnt_r, match_cnt_s, match_inc_s;
  logic [UW-1:0]    miss_cnt_r, miss_cnt_s, miss_inc_s;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_s, err_base_s;
  logic             locked_r, err_pulse_r, err_pulse_s, count_s;

  assign match_inc_s = match_cnt_r + MW'(1);
  assign miss_inc_s  = miss_cnt_r + UW'(1);

  // Next-state, reference and counter update for the sampled word
  always_comb begin
    state_s     = state_r;
    expected_s  = expected_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    err_pulse_s = 1'b0;
    count_s     = 1'b0;
    if (din_valid) begin
      case (state_r)
        HUNT: begin
          if (din != {WIDTH{1'b0}}) begin
            expected_s  = lfsr_next(din);
            match_cnt_s = {MW{1'b0}};
            state_s     = VERIFY;
          end else begin
            state_s = HUNT;
          end
        end
        VERIFY: begin
          if (din == expected_r) begin
            match_cnt_s = match_inc_s;
            expected_s  = lfsr_next(expected_r);
            if (match_inc_s == LOCK_LIM) begin
              state_s    = LOCKED;
              miss_cnt_s = {UW{1'b0}};
            end else begin
              state_s = VERIFY;
            end
          end else if (din != {WIDTH{1'b0}}) begin
            // Reseed from the received word rather than waiting in HUNT
            expected_s  = lfsr_next(din);
            match_cnt_s = {MW{1'b0}};
            state_s     = VERIFY;
          end else begin
            state_s = HUNT;
          end
        end
        LOCKED: begin
          expected_s = lfsr_next(expected_r);
          if (din == expected_r) begin
            miss_cnt_s = {UW{1'b0}};
          end else begin
            err_pulse_s = 1'b1;
            count_s     = 1'b1;
            miss_cnt_s  = miss_inc_s;
            if (miss_inc_s == UNLOCK_LIM) begin
              state_s = HUNT;
            end else begin
              state_s = LOCKED;
            end
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // Clear takes effect first so a simultaneous mismatch lands on one
    err_base_s = clr_err ? {ERR_W{1'b0}} : err_cnt_r;
    if (count_s && (err_base_s != {ERR_W{1'b1}})) begin
      err_cnt_s = err_base_s + ERR_W'(1);
    end else begin
      err_cnt_s = err_base_s;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r     <= HUNT;
      expected_r  <= {WIDTH{1'b0}};
      match_cnt_r <= {MW{1'b0}};
      miss_cnt_r  <= {UW{1'b0}};
      err_cnt_r   <= {ERR_W{1'b0}};
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      expected_r  <= expected_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      err_cnt_r   <= err_cnt_s;
      locked_r    <= (state_s == LOCKED);
      err_pulse_r <= err_pulse_s;
    end
  end

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_cnt   = err_cnt_r;
  assign expected  = expected_r;

endmodule
